// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers a 4-digit hex value from a multiplexed active-low 7-segment bus
module seg7_scan_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_n,
  input  logic [3:0]  an_n,
  output logic [15:0] value,
  output logic [3:0]  blank,
  output logic        frame_valid,
  output logic        digit_err,
  output logic        anode_err,
  output logic        timeout
);
  logic [10:0] s1, s2, prev;
  logic [7:0] cnt;
  logic [23:0] idle;
  logic [3:0][3:0] nib;
  logic [3:0] blk, seen, seen_next, an, sel, seen_base;
  logic [6:0] sg;
  logic [5:0] d;
  logic same, cap, one_low, multi, good, bad, tmo;
  function automatic logic [5:0] dec(input logic [6:0] s);
    case (s)
      7'h40: dec = 6'h20;
      7'h79: dec = 6'h21;
      7'h24: dec = 6'h22;
      7'h30: dec = 6'h23;
      7'h19: dec = 6'h24;
      7'h12: dec = 6'h25;
      7'h02: dec = 6'h26;
      7'h78: dec = 6'h27;
      7'h00: dec = 6'h28;
      7'h10: dec = 6'h29;
      7'h08: dec = 6'h2A;
      7'h03: dec = 6'h2B;
      7'h46: dec = 6'h2C;
      7'h21: dec = 6'h2D;
      7'h06: dec = 6'h2E;
      7'h0E: dec = 6'h2F;
      7'h7F: dec = 6'h30;
      default: dec = 6'h00;
    endcase
  endfunction
  always_comb begin
    an = s2[10:7];
    sg = s2[6:0];
    sel = ~an;
    d = dec(sg);
    same = s2 == prev;
    cap = same && cnt == 8'(STABLE_CYCLES - 2);
    one_low = an != 4'hF && (sel & (sel - 4'd1)) == 4'd0;
    multi = an != 4'hF && !one_low;
    good = cap && one_low && d[5];
    bad = cap && one_low && !d[5];
    tmo = !good && seen != 4'h0 && seen != 4'hF && idle == 24'(TIMEOUT_CYCLES - 1);
    seen_base = (seen == 4'hF || tmo) ? 4'h0 : seen;
    seen_next = good ? (seen_base | sel) : bad ? (seen_base & ~sel) : seen_base;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '1;
      s2 <= '1;
      prev <= '1;
      cnt <= '0;
      idle <= '0;
      seen <= '0;
      nib <= '0;
      blk <= '0;
      value <= '0;
      blank <= '0;
      frame_valid <= 1'b0;
      digit_err <= 1'b0;
      anode_err <= 1'b0;
      timeout <= 1'b0;
    end else begin
      s1 <= {an_n, seg_n};
      s2 <= s1;
      prev <= s2;
      cnt <= !same ? 8'd0 : (cnt == 8'(STABLE_CYCLES) ? cnt : cnt + 8'd1);
      idle <= (good || idle == 24'(TIMEOUT_CYCLES - 1)) ? 24'd0 : idle + 24'd1;
      seen <= seen_next;
      for (int i = 0; i < 4; i++)
        if (good && sel[i]) begin
          nib[i] <= d[3:0];
          blk[i] <= d[4];
        end
      if (seen == 4'hF) begin
        value <= nib;
        blank <= blk;
      end
      frame_valid <= seen == 4'hF;
      digit_err <= bad;
      anode_err <= cap && multi;
      timeout <= tmo;
    end
  end
endmodule
